// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and status logic for the async FIFO.
// Keeps the write binary/Gray pointers and drives the RAM write address.
// Turns the synchronised read Gray pointer into registered full, almost-full,
// fill level and a sticky overflow flag. The status flags are deliberately
// pessimistic: the read pointer they see is stale, so they may over-report
// the fill level but never under-report it.
module wptr_full_ctrl #(
    parameter int ADDRSIZE  = 4,
    parameter int AFULL_LVL = 12
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam logic [ADDRSIZE:0] AFULL_THR = (ADDRSIZE+1)'(AFULL_LVL);

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] levelnext;
    logic [ADDRSIZE:0] full_cmp;
    logic              wen;

    // Next pointer values; a write is dropped while full so the pointers hold.
    always_comb begin
        wen       = winc & ~wfull;
        wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wen};
        wgraynext = (wbinnext >> 1) ^ wbinnext;
    end

    // Gray-to-binary of the synchronised read pointer (XOR prefix from the MSB).
    always_comb begin
        rbin[ADDRSIZE] = wq2_rptr[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ wq2_rptr[i];
        end
    end

    // Full pattern: read Gray pointer with its top two bits inverted.
    always_comb begin
        full_cmp  = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
        levelnext = wbinnext - rbin;
    end

    assign waddr = wbin[ADDRSIZE-1:0];

    // Pointer registers; only the Gray copy crosses into the read domain.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin <= '0;
            wptr <= '0;
        end else begin
            wbin <= wbinnext;
            wptr <= wgraynext;
        end
    end

    // Status flags, all computed from the same next-state values so they agree.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
        end else begin
            wfull        <= (wgraynext == full_cmp);
            walmost_full <= (levelnext >= AFULL_THR);
            wlevel       <= levelnext;
        end
    end

    // Sticky overflow; a dropped write in the same cycle as a clear still sets it.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            woverflow <= 1'b0;
        end else if (winc & wfull) begin
            woverflow <= 1'b1;
        end else if (wovf_clr) begin
            woverflow <= 1'b0;
        end
    end

endmodule
